fp_normalizer: RTL and testbench

FP_NORMALIZER -- requirements
Module: fp_normalizer

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_pack.sv | 17 +
 rtl/fp_normalizer.sv | 100 ++++++++++
 tb/tb_fp_normalizer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the floating-point normalizer
package fp_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {PK_NORM, PK_INF, PK_PZERO, PK_SZERO} pack_e;
  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;
endpackage

// File: rtl/fp_pack.sv
// fp_pack: assembles the single-precision word or one of the special encodings
module fp_pack
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  logic [7:0]        exp_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  pack_e             mode_i,
  output fp_word_t          word_o
);
  // pick between the normal encoding and the zero/infinity words
  always_comb
    word_o = mode_i == PK_PZERO ? '0 :
             mode_i == PK_SZERO ? {sign_i, 31'b0} :
             mode_i == PK_INF   ? {sign_i, EXP_MAX, {FRAC_W{1'b0}}} :
                                  {sign_i, exp_i, frac_i};
endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization of an FP result into an IEEE-754 word
module fp_normalizer #(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exponent_in,
  input  logic              carry_in,
  input  logic [MANT_W-1:0] mantissa_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);
  import fp_pkg::*;
  state_e            state_q;
  logic              sign_q, sign_d, done_d, load;
  logic [EXP_W-1:0]  exp_q, exp_d, shl_exp;
  logic [MANT_W-1:0] mant_q, mant_d, shl_mant;
  pack_e             mode_d;
  fp_word_t          word;
  logic [31:0]       result_q;
  logic              overflow_q, underflow_q;
  assign shl_mant  = mant_q << 1;
  assign shl_exp   = exp_q - 1'b1;
  assign load      = (state_q == IDLE && in_valid) || state_q == SHIFT;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  // next datapath values: classify the incoming result in IDLE, one shift step in SHIFT
  always_comb begin
    sign_d = state_q == IDLE ? sign_in : sign_q;
    exp_d  = shl_exp;
    mant_d = shl_mant;
    done_d = shl_mant[MANT_W-1] || shl_exp == EXP_W'(1);
    mode_d = (!shl_mant[MANT_W-1] && shl_exp == EXP_W'(1)) ? PK_SZERO : PK_NORM;
    if (state_q == IDLE) begin
      exp_d  = exponent_in;
      mant_d = mantissa_in;
      done_d = 1'b1;
      mode_d = PK_NORM;
      if (exponent_in != EXP_MAX) begin
        if (carry_in) begin
          exp_d  = exponent_in + 1'b1;
          mant_d = {1'b1, mantissa_in[MANT_W-1:1]};
          mode_d = exponent_in == EXP_MAX - 1'b1 ? PK_INF : PK_NORM;
        end else if (mantissa_in == '0) begin
          mode_d = PK_PZERO;
        end else if (!mantissa_in[MANT_W-1]) begin
          done_d = exponent_in <= EXP_W'(1);
          mode_d = exponent_in <= EXP_W'(1) ? PK_SZERO : PK_NORM;
        end
      end
    end
  end
  fp_pack u_pack (
    .sign_i (sign_d),
    .exp_i  (exp_d),
    .frac_i (mant_d[FRAC_W-1:0]),
    .mode_i (mode_d),
    .word_o (word)
  );
  // control FSM plus datapath and registered result/flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q  <= sign_d;
          exp_q   <= exp_d;
          mant_q  <= mant_d;
          state_q <= done_d ? DONE : SHIFT;
        end
        SHIFT: begin
          exp_q  <= exp_d;
          mant_q <= mant_d;
          if (done_d) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (load && done_d) begin
        result_q    <= word;
        overflow_q  <= mode_d == PK_INF;
        underflow_q <= mode_d == PK_SZERO;
      end
    end
  end
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed and randomized checks against a behavioural normalizer model
module tb_fp_normalizer;
  logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, sign_in = 1'b0;
  logic        carry_in = 1'b0, out_ready = 1'b0;
  logic [7:0]  exponent_in = '0;
  logic [23:0] mantissa_in = '0;
  logic        in_ready, out_valid, overflow, underflow;
  logic [31:0] result;
  int          n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  fp_normalizer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_in     (sign_in),
    .exponent_in (exponent_in),
    .carry_in    (carry_in),
    .mantissa_in (mantissa_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // reference: leading-zero count and exponent arithmetic straight from the rules
  task automatic model(input logic s, input logic [7:0] e, input logic c, input logic [23:0] m,
                       output logic [31:0] r, output logic o, output logic u, output int lat);
    int ei, k;
    logic [23:0] mn;
    ei = int'(e);
    lat = 1; o = 1'b0; u = 1'b0;
    if (e == 8'hFF) r = {s, 8'hFF, m[22:0]};
    else if (c) begin
      ei = ei + 1;
      if (ei == 255) begin r = {s, 8'hFF, 23'b0}; o = 1'b1; end
      else r = {s, 8'(ei), m[23:1]};
    end else if (m == 0) r = 32'h0;
    else begin
      k = 0;
      while (k < 24 && !m[23-k]) k++;
      if (k == 0 || ei - k >= 1) begin
        mn = m << k;
        r = {s, 8'(ei - k), mn[22:0]};
        lat = k + 1;
      end else begin
        r = {s, 31'b0};
        u = 1'b1;
        lat = (ei > 1 ? ei - 1 : 0) + 1;
      end
    end
  endtask

  task automatic run_op(input logic s, input logic [7:0] e, input logic c, input logic [23:0] m,
                        input logic [31:0] xr, input logic xo, input logic xu, input int xl, input int hold);
    int lat;
    chk("in_ready_idle", in_ready, 1);
    sign_in = s; exponent_in = e; carry_in = c; mantissa_in = m; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clock); #1; lat++; end
    chk("latency", lat, xl);
    chk("result", result, xr);
    chk("overflow", overflow, xo);
    chk("underflow", underflow, xu);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; sign_in = ~s; exponent_in = 8'h40; mantissa_in = 24'h800000;
      @(posedge clock); #1;
      chk("hold_result", result, xr);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("taken_valid", out_valid, 0);
    chk("taken_in_ready", in_ready, 1);
  endtask

  initial begin
    logic        s, c, xo, xu;
    logic [7:0]  e;
    logic [23:0] m;
    logic [31:0] xr;
    int          xl, sel;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    run_op(1'b0, 8'h80, 1'b0, 24'hC00000, 32'h40400000, 1'b0, 1'b0, 1, 3);
    run_op(1'b0, 8'h7F, 1'b1, 24'h000000, 32'h40000000, 1'b0, 1'b0, 1, 0);
    run_op(1'b0, 8'h85, 1'b0, 24'h000001, 32'h37000000, 1'b0, 1'b0, 24, 0);
    run_op(1'b1, 8'hFE, 1'b1, 24'h800000, 32'hFF800000, 1'b1, 1'b0, 1, 0);
    run_op(1'b0, 8'hFF, 1'b1, 24'h123456, 32'h7F923456, 1'b0, 1'b0, 1, 0);
    run_op(1'b1, 8'h00, 1'b0, 24'h400000, 32'h80000000, 1'b0, 1'b1, 1, 0);
    run_op(1'b1, 8'h03, 1'b0, 24'h100000, 32'h80000000, 1'b0, 1'b1, 3, 0);
    sign_in = 1'b0; exponent_in = 8'h85; carry_in = 1'b0; mantissa_in = 24'h000001; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("shift_valid", out_valid, 0);
    chk("shift_in_ready", in_ready, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    chk("midrst_underflow", underflow, 0);
    repeat (30) begin @(posedge clock); #1; end
    chk("midrst_no_output", out_valid, 0);
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      sel = int'($urandom_range(0, 7));
      e = sel == 0 ? 8'hFF : sel == 1 ? 8'hFE : sel == 2 ? 8'($urandom_range(0, 4)) : 8'($urandom);
      c = $urandom_range(0, 3) == 0;
      m = 24'($urandom) >> $urandom_range(0, 24);
      model(s, e, c, m, xr, xo, xu, xl);
      run_op(s, e, c, m, xr, xo, xu, xl, int'($urandom_range(0, 2)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
